// File: rtl/io_timer_switch.sv
// MIPS IO-bus peripheral: debounced board switches plus a reloadable down-counting
// tick timer with sticky TICK/MISSED flags that software polls to pace the game loop.

module io_sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic sw_raw,
  output logic sw_db
);
  localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          sw_meta, sw_sync;
  logic [DW-1:0] cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
      sw_db   <= 1'b0;
      cnt     <= '0;
    end else begin
      sw_meta <= sw_raw;
      sw_sync <= sw_meta;
      // Any return to the accepted level restarts the stability window.
      if (sw_sync == sw_db) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        sw_db <= sw_sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end
endmodule

module io_timer_switch #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 24
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  IOAddr,
  input  logic        IOWriteEn,
  input  logic [31:0] IOWriteData,
  input  logic [1:0]  SWITCHES,
  output logic [31:0] IOReadData,
  output logic        TICK_PENDING
);
  localparam logic [3:0] A_SW     = 4'h4;
  localparam logic [3:0] A_RELOAD = 4'h8;
  localparam logic [3:0] A_CTRL   = 4'h9;
  localparam logic [3:0] A_STATUS = 4'hA;
  localparam logic [3:0] A_COUNT  = 4'hB;

  logic [1:0]       sw_db;
  logic [CNT_W-1:0] reload, count;
  logic             enable, tick, missed;
  logic             wr_reload, wr_ctrl, clr_tick, clr_missed, running, expire;
  logic             unused_wdata;

  io_sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
    .CLK    (CLK),
    .RESET  (RESET),
    .sw_raw (SWITCHES),
    .sw_db  (sw_db)
  );

  assign unused_wdata = ^IOWriteData[31:CNT_W];

  assign wr_reload  = IOWriteEn && (IOAddr == A_RELOAD);
  assign wr_ctrl    = IOWriteEn && (IOAddr == A_CTRL);
  assign clr_tick   = IOWriteEn && (IOAddr == A_STATUS) && IOWriteData[0];
  assign clr_missed = IOWriteEn && (IOAddr == A_STATUS) && IOWriteData[1];
  assign running    = enable && (reload != '0);
  // A RELOAD store on the expiry cycle pre-empts the tick.
  assign expire     = running && (count == '0) && !wr_reload;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      reload <= '0;
      count  <= '0;
      enable <= 1'b0;
      tick   <= 1'b0;
      missed <= 1'b0;
    end else begin
      if (wr_reload) begin
        reload <= IOWriteData[CNT_W-1:0];
        count  <= IOWriteData[CNT_W-1:0];
      end else if (running) begin
        count  <= (count == '0) ? reload : count - CNT_W'(1);
      end

      if (wr_ctrl) enable <= IOWriteData[0];

      // Set beats clear; a clear landing on expiry also suppresses MISSED.
      if (expire)        tick <= 1'b1;
      else if (clr_tick) tick <= 1'b0;

      if (expire && tick && !clr_tick) missed <= 1'b1;
      else if (clr_missed)             missed <= 1'b0;
    end
  end

  always_comb begin
    IOReadData = '0;
    case (IOAddr)
      A_SW:     IOReadData = {30'b0, sw_db};
      A_RELOAD: IOReadData = 32'(reload);
      A_CTRL:   IOReadData = {31'b0, enable};
      A_STATUS: IOReadData = {30'b0, missed, tick};
      A_COUNT:  IOReadData = 32'(count);
      default:  IOReadData = '0;
    endcase
  end

  assign TICK_PENDING = tick;
endmodule

// File: tb/tb_io_timer_switch.sv
// Randomised and directed bench for io_timer_switch against a behavioural model
// (sliding-window debounce, rule-based timer) kept entirely in the bench.

`timescale 1ns/1ps
module tb_io_timer_switch;
  localparam int D  = 4;
  localparam int CW = 24;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic [3:0]  IOAddr = '0;
  logic        IOWriteEn = 1'b0;
  logic [31:0] IOWriteData = '0;
  logic [1:0]  SWITCHES = '0;
  logic [31:0] IOReadData;
  logic        TICK_PENDING;

  int n_cmp = 0, n_err = 0;

  io_timer_switch #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .IOAddr(IOAddr), .IOWriteEn(IOWriteEn),
    .IOWriteData(IOWriteData), .SWITCHES(SWITCHES), .IOReadData(IOReadData),
    .TICK_PENDING(TICK_PENDING)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CW-1:0] m_reload, m_count;
  logic          m_en, m_tick, m_missed;
  logic [1:0]    m_s1, m_s2, m_db;
  logic [1:0]    win[$];

  task automatic m_reset();
    m_reload = '0; m_count = '0; m_en = 0; m_tick = 0; m_missed = 0;
    m_s1 = '0; m_s2 = '0; m_db = '0;
    win.delete();
    for (int i = 0; i < D; i++) win.push_back(2'b00);
  endtask

  task automatic m_step(input logic we, input logic [3:0] a, input logic [31:0] d);
    bit wr_rel  = we && a == 4'h8;
    bit running = m_en && m_reload != 0;
    bit fire    = running && m_count == 0 && !wr_rel;
    bit clr_t   = we && a == 4'hA && d[0];
    bit clr_m   = we && a == 4'hA && d[1];
    // switch accepted once the last D synchronised samples all disagree with it
    win.push_back(m_s2);
    if (win.size() > D) void'(win.pop_front());
    for (int b = 0; b < 2; b++) begin
      bit all_diff = 1;
      foreach (win[i]) if (win[i][b] == m_db[b]) all_diff = 0;
      if (all_diff) m_db[b] = ~m_db[b];
    end
    m_s2 = m_s1; m_s1 = SWITCHES;
    if (fire && m_tick && !clr_t) m_missed = 1; else if (clr_m) m_missed = 0;
    if (fire) m_tick = 1; else if (clr_t) m_tick = 0;
    if (wr_rel) begin
      m_reload = d[CW-1:0]; m_count = d[CW-1:0];
    end else if (running) begin
      m_count = (m_count == 0) ? m_reload : m_count - 1;
    end
    if (we && a == 4'h9) m_en = d[0];
  endtask

  function automatic logic [31:0] m_rd(input logic [3:0] a);
    case (a)
      4'h4:    return {30'b0, m_db};
      4'h8:    return 32'(m_reload);
      4'h9:    return {31'b0, m_en};
      4'hA:    return {30'b0, m_missed, m_tick};
      4'hB:    return 32'(m_count);
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- bus helpers ----------------
  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    IOAddr = a; #1; v = IOReadData;
  endtask

  task automatic check_all();
    logic [31:0] v;
    logic [3:0]  al[5] = '{4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
    logic [3:0]  u = 4'($urandom_range(0, 15));
    foreach (al[i]) begin
      rd(al[i], v);
      chk($sformatf("rd%0h", al[i]), v, m_rd(al[i]));
    end
    if (u == 4'h4 || (u >= 4'h8 && u <= 4'hB)) u = 4'hC;
    rd(u, v);
    chk($sformatf("rd_unl%0h", u), v, 32'h0);
    chk("tick_pending", {31'b0, TICK_PENDING}, {31'b0, m_tick});
  endtask

  task automatic cyc(input logic we, input logic [3:0] a, input logic [31:0] d);
    IOWriteEn = we; IOAddr = a; IOWriteData = d;
    @(posedge CLK);
    m_step(we, a, d);
    #1 IOWriteEn = 0;
    check_all();
  endtask

  task automatic wait_cnt(input logic [31:0] target, output bit ok);
    logic [31:0] v;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      rd(4'hB, v);
      if (v == target) ok = 1; else cyc(0, 4'h0, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    logic [31:0] exp_seq[6] = '{4, 3, 2, 1, 0, 5};
    int lat, rise;
    bit ok;

    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    foreach (exp_seq[i]) begin end
    for (int a = 4; a <= 11; a++) begin
      if (a == 4 || a >= 8) begin
        rd(4'(a), v);
        chk($sformatf("reset_rd%0h", a), v, 32'h0);
      end
    end
    chk("reset_tick_pending", {31'b0, TICK_PENDING}, 32'h0);
    RESET = 0;

    // debounce latency and glitch rejection
    SWITCHES = 2'b10;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      cyc(0, 4'h0, 0);
      rd(4'h4, v);
      if (v == 32'h2) lat = k;
    end
    chk("sw_latency", lat, 6);
    SWITCHES = 2'b01;
    repeat (3) cyc(0, 4'h0, 0);
    SWITCHES = 2'b10;
    repeat (8) cyc(0, 4'h0, 0);
    rd(4'h4, v);
    chk("sw_glitch", v, 32'h2);

    // periodic tick with RELOAD=5
    cyc(1, 4'h8, 5);
    cyc(1, 4'h9, 1);
    rd(4'hB, v);
    chk("cnt_seq_start", v, 5);
    rise = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 4'h0, 0);
      rd(4'hB, v);
      chk($sformatf("cnt_seq%0d", k), v, exp_seq[k-1]);
      rd(4'hA, v);
      if (v[0] && rise == 0) rise = k;
    end
    chk("tick_rise", rise, 6);
    repeat (6) cyc(0, 4'h0, 0);
    rd(4'hA, v);
    chk("missed_set", v, 3);
    cyc(1, 4'hA, 1);
    rd(4'hA, v);
    chk("w1c_tick", v, 2);
    cyc(1, 4'hA, 2);
    rd(4'hA, v);
    chk("w1c_missed", v, 0);

    // collisions on the expiry cycle
    wait_cnt(0, ok);
    chk("wait_cnt0_a", ok, 1);
    cyc(1, 4'hA, 1);
    rd(4'hA, v);
    chk("expire_vs_clear", v, 1);
    wait_cnt(0, ok);
    chk("wait_cnt0_b", ok, 1);
    cyc(1, 4'h8, 9);
    rd(4'hB, v);
    chk("expire_vs_reload_cnt", v, 9);
    rd(4'hA, v);
    chk("expire_vs_reload_status", v, 1);

    // asynchronous reset mid-count
    wait_cnt(3, ok);
    chk("wait_cnt3", ok, 1);
    RESET = 1;
    #1;
    rd(4'hB, v); chk("areset_cnt", v, 0);
    rd(4'h9, v); chk("areset_ctrl", v, 0);
    rd(4'hA, v); chk("areset_status", v, 0);
    chk("areset_tick_pending", {31'b0, TICK_PENDING}, 32'h0);
    m_reset();
    RESET = 0;
    repeat (20) cyc(0, 4'h0, 0);
    rd(4'hA, v);
    chk("no_tick_after_reset", v, 0);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  al[10] = '{4'h4, 4'h8, 4'h8, 4'h9, 4'h9, 4'hA, 4'hB, 4'hC, 4'h0, 4'hF};
      logic [3:0]  a = al[$urandom_range(0, 9)];
      logic [31:0] d = $urandom;
      if (a == 4'h8) d = (d & 32'hFFFF_FF00) | 32'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) SWITCHES = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) cyc(1, a, d);
      else cyc(0, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
